// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with pause, abort, auto-reload and expiry pulse
//   clock        - rising-edge clock
//   reset        - asynchronous active-low reset
//   load_value   - start value, captured only when a start is accepted in IDLE
//   start        - run request (honoured in IDLE only, even alongside abort)
//   pause        - level; freezes an active countdown (RUN -> HOLD)
//   abort        - cancels an active countdown, clearing count without done
//   auto_reload  - level; sampled at each expiry to restart from the captured value
//   count        - current count (registered)
//   busy         - high while in RUN or HOLD (registered)
//   done         - one-cycle expiry pulse (registered)
//   expire_count - expiries since the last accepted start, saturating at 15
module countdown_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [3:0]       expire_count
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_reload, w_count, w_reload;
  logic [3:0]       w_exp;
  logic             w_done;
  always_comb begin
    w_next   = r_state;
    w_count  = count;
    w_reload = r_reload;
    w_exp    = expire_count;
    w_done   = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_next   = RUN;
        w_count  = load_value;
        w_reload = load_value;
        w_exp    = '0;
      end
      RUN: if (abort) begin
        w_next  = IDLE;
        w_count = '0;
      end else if (pause) begin
        w_next = HOLD;
      end else if (count == '0) begin
        // expiry: pulse, count it, then either reload from the captured value or stop
        w_done = 1'b1;
        w_exp  = (expire_count == 4'd15) ? expire_count : expire_count + 4'd1;
        w_count = auto_reload ? r_reload : '0;
        w_next  = auto_reload ? RUN : IDLE;
      end else begin
        w_count = count - WIDTH'(1);
      end
      HOLD: if (abort) begin
        w_next  = IDLE;
        w_count = '0;
      end else if (!pause) begin
        w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end
  // busy follows the next state so it drops together with a non-reload done
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      count        <= '0;
      r_reload     <= '0;
      expire_count <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_next;
      count        <= w_count;
      r_reload     <= w_reload;
      expire_count <= w_exp;
      done         <= w_done;
      busy         <= (w_next != IDLE);
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer (WIDTH=3)
module tb_countdown_timer;
  localparam int W = 3;
  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0, pause = 1'b0, abort = 1'b0, auto_reload = 1'b0;
  logic [W-1:0] count;
  logic         busy, done;
  logic [3:0]   expire_count;
  int n_checks = 0;
  int n_fail = 0;

  countdown_timer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .load_value(load_value), .start(start),
    .pause(pause), .abort(abort), .auto_reload(auto_reload), .count(count),
    .busy(busy), .done(done), .expire_count(expire_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({count, busy, done, expire_count} !== {3'd0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d busy=%0b done=%0b exp=%0d expected 0/0/0/0", count, busy, done, expire_count);
    end
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    load_value = 3'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    load_value = 3'd7;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (count !== 3'(5 - i) || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_count[%0d]: got count=%0d busy=%0b done=%0b expected %0d/1/0", i, count, busy, done, 5 - i);
      end
      step();
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || expire_count !== 4'd1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL basic_expiry: got done=%0b busy=%0b exp=%0d count=%0d expected 1/0/1/0", done, busy, expire_count, count);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: got done=%0b busy=%0b expected 0/0", done, busy);
    end
  endtask

  task automatic test_auto_reload();
    load_value = 3'd2;
    auto_reload = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k <= 50; k++) begin
      int ec = (k / 3 > 15) ? 15 : k / 3;
      logic [W-1:0] exp_cnt = (k % 3 == 0) ? 3'd2 : (k % 3 == 1) ? 3'd1 : 3'd0;
      logic exp_done = (k > 0) && (k % 3 == 0);
      n_checks++;
      if (count !== exp_cnt || done !== exp_done || expire_count !== 4'(ec) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reload[%0d]: got count=%0d done=%0b exp=%0d busy=%0b expected %0d/%0b/%0d/1", k, count, done, expire_count, busy, exp_cnt, exp_done, ec);
      end
      step();
    end
    auto_reload = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_abort: got count=%0d busy=%0b done=%0b expected 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_pause();
    load_value = 3'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (count !== 3'd3 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold[%0d]: got count=%0d busy=%0b done=%0b expected 3/1/0", i, count, busy, done);
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] e = (i == 0) ? 3'd3 : 3'(3 - i);
      step();
      n_checks++;
      if (count !== e || done !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_resume[%0d]: got count=%0d done=%0b expected %0d/0", i, count, done, e);
      end
    end
    step();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_done: got done=%0b busy=%0b expected 1/0", done, busy);
    end
    step();
  endtask

  task automatic test_abort_ignored_start();
    load_value = 3'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    load_value = 3'd2;
    step();
    start = 1'b0;
    n_checks++;
    if (count !== 3'd5 || expire_count !== 4'd0) begin
      n_fail++;
      $display("FAIL ignored_start: got count=%0d exp=%0d expected 5/0", count, expire_count);
    end
    step();
    pause = 1'b1;
    step();
    n_checks++;
    if (count !== 3'd4 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_count: got count=%0d busy=%0b expected 4/1", count, busy);
    end
    abort = 1'b1;
    step();
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_abort: got count=%0d busy=%0b done=%0b expected 0/0/0", count, busy, done);
    end
    abort = 1'b0;
    pause = 1'b0;
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: got done=%0b busy=%0b expected 0/0", done, busy);
    end
    load_value = 3'd3;
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_checks++;
    if (count !== 3'd3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_start_abort: got count=%0d busy=%0b expected 3/1", count, busy);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_zero_load();
    load_value = 3'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (count !== 3'd0 || busy !== 1'b1 || done !== 1'b0 || expire_count !== 4'd0) begin
      n_fail++;
      $display("FAIL zero_start: got count=%0d busy=%0b done=%0b exp=%0d expected 0/1/0/0", count, busy, done, expire_count);
    end
    step();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || expire_count !== 4'd1) begin
      n_fail++;
      $display("FAIL zero_done: got done=%0b busy=%0b exp=%0d expected 1/0/1", done, busy, expire_count);
    end
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_single: got done=%0b expected 0", done);
    end
    auto_reload = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b1 || expire_count !== 4'(k)) begin
        n_fail++;
        $display("FAIL zero_reload[%0d]: got done=%0b busy=%0b exp=%0d expected 1/1/%0d", k, done, busy, expire_count, k);
      end
    end
    auto_reload = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_async_reset();
    load_value = 3'd6;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL areset_pre: got count=%0d expected 4", count);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({count, busy, done, expire_count} !== {3'd0, 1'b0, 1'b0, 4'd0}) begin
      n_fail++;
      $display("FAIL areset_immediate: got count=%0d busy=%0b done=%0b exp=%0d expected 0/0/0/0", count, busy, done, expire_count);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || count !== 3'd0) begin
        n_fail++;
        $display("FAIL areset_quiet[%0d]: got done=%0b busy=%0b count=%0d expected 0/0/0", i, done, busy, count);
      end
    end
    load_value = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (count !== 3'd1 || busy !== 1'b1 || expire_count !== 4'd0) begin
      n_fail++;
      $display("FAIL areset_restart: got count=%0d busy=%0b exp=%0d expected 1/1/0", count, busy, expire_count);
    end
    step();
    step();
    n_checks++;
    if (done !== 1'b1 || expire_count !== 4'd1) begin
      n_fail++;
      $display("FAIL areset_restart_done: got done=%0b exp=%0d expected 1/1", done, expire_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_auto_reload();
    test_pause();
    test_abort_ignored_start();
    test_zero_load();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 3, giving the count and load width in bits.
REQ-002 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The module SHALL have port load_value, input, WIDTH bits: start value, sampled only when a start is accepted.
REQ-005 The module SHALL have port start, input, 1 bit: run request, sampled each rising edge.
REQ-006 The module SHALL have port pause, input, 1 bit: level; 1 freezes an active countdown.
REQ-007 The module SHALL have port abort, input, 1 bit: cancels an active countdown.
REQ-008 The module SHALL have port auto_reload, input, 1 bit: level; sampled at each expiry.
REQ-009 The module SHALL have port count, output, WIDTH bits: current count value, registered.
REQ-010 The module SHALL have port busy, output, 1 bit: 1 while in RUN or HOLD, registered.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle expiry pulse, registered.
REQ-012 The module SHALL have port expire_count, output, 4 bits: number of expiries since last accepted start, saturating.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, HOLD.
REQ-014 In IDLE with start=1, the block SHALL load count<=load_value, store reload_reg<=load_value, clear expire_count, and go to RUN.
REQ-015 In IDLE, abort and pause SHALL be ignored; with start=1 and abort=1 together, the start SHALL be accepted.
REQ-016 In RUN, start SHALL be ignored; no restart or reload occurs.
REQ-017 In HOLD, start SHALL be ignored; no restart or reload occurs.
REQ-018 Priority in RUN, highest first: abort, pause, expiry, decrement.
REQ-019 In RUN with abort=1, the next state SHALL be IDLE, count SHALL be <=0, and done SHALL stay 0.
REQ-020 In RUN with pause=1, the next state SHALL be HOLD and count SHALL hold; this includes count==0, with no expiry taken.
REQ-021 In RUN with count!=0, count SHALL decrement by 1 per edge with no wrap.
REQ-022 In RUN with count==0, the block SHALL assert done=1 for exactly one cycle and increment expire_count, saturating at 15.
REQ-023 At expiry, if auto_reload=1 the block SHALL set count<=reload_reg and stay in RUN; otherwise it SHALL stay at count=0 and go to IDLE.
REQ-024 In HOLD with abort=1, the next state SHALL be IDLE and count SHALL be <=0, with no done.
REQ-025 In HOLD with pause=0, the block SHALL return to RUN; the decrement resumes on the following edge.
REQ-026 Latency: after start is accepted at edge E with load_value=N, count SHALL equal 0 after edge E+N and done SHALL be 1 after edge E+N+1.
REQ-027 load_value=0 SHALL give done one cycle after the start edge; with auto_reload=1, done SHALL then pulse every cycle.
REQ-028 done SHALL never be 1 in two consecutive cycles, except in the continuous-expiry case of REQ-027.
REQ-029 busy SHALL drop in the same cycle that done pulses for a non-reload expiry.
REQ-030 Changes to load_value after the start edge SHALL have no effect on the current run or its reloads.

Reset
REQ-031 When reset=0, regardless of clock, the block SHALL set state=IDLE, count=0, reload_reg=0, busy=0, done=0, expire_count=0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no done pulse.
REQ-033 After reset is released, the first start SHALL behave exactly as in REQ-014.

Verification (WIDTH=3)
REQ-034 Basic run: start with load_value=5 at edge 0, pause=0, auto_reload=0 -> count 5,4,3,2,1,0 after edges 0..5; after edge 6 done=1 for one cycle, busy=0, expire_count=1.
REQ-035 Auto-reload: start with load_value=2, auto_reload=1 -> count 2,1,0,2,1,0,...; done pulses every 3rd cycle; expire_count reaches 15 and holds.
REQ-036 Pause: pause=1 for 4 cycles while count=3 -> count stays 3, busy=1, done=0; after release, count goes 2,1,0 then done.
REQ-037 Abort and ignored start: abort in HOLD at count=4 -> count=0, busy=0, no done; start pulsed mid-run -> count sequence unaffected.
REQ-038 Zero load: start with load_value=0 -> done=1 after the next edge, busy=0, expire_count=1.
REQ-039 Async reset: reset driven to 0 between clock edges while count=4 -> count=0, busy=0, done=0, expire_count=0 immediately, with no done afterwards.
